// File: rtl/hpu_bundle_pkg.sv
// Shared types and constants for the bipolar bundler: FSM states, lane
// contribution literals, saturation bound and the tie-break LFSR.
package hpu_bundle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    localparam logic signed [1:0] POS_ONE = 2'sb01;
    localparam logic signed [1:0] NEG_ONE = 2'sb11;
    localparam logic signed [1:0] ZERO    = 2'sb00;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Symmetric clamp keeps +max and -max equidistant from zero.
    function automatic int acc_max(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/bipolar_bundler_if.sv
// Beat input and bundled-result output bus of the bipolar bundler.
interface bipolar_bundler_if #(
    parameter int LANES  = 32,
    parameter int BEAT_W = 16
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_store;
    logic [LANES-1:0]  in_bits;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [LANES-1:0]  out_bits;
    logic [BEAT_W-1:0] out_beats;
    logic              out_sat;

    modport master (
        output start, in_valid, in_store, in_bits, in_last, out_ready,
        input  in_ready, out_valid, out_bits, out_beats, out_sat
    );

    modport slave (
        input  start, in_valid, in_store, in_bits, in_last, out_ready,
        output in_ready, out_valid, out_bits, out_beats, out_sat
    );
endinterface

// File: rtl/bundle_lane.sv
// One saturating signed accumulator lane; sign/zero/sat describe the value
// being loaded this cycle so the top can capture the final beat's result.
module bundle_lane
    import hpu_bundle_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic store,
    input  logic hv_bit,
    output logic sign,
    output logic zero,
    output logic sat
);
    localparam logic signed [CNT_W:0] MAX = (CNT_W + 1)'(acc_max(CNT_W));
    localparam logic signed [CNT_W:0] MIN = -MAX;

    logic signed [CNT_W-1:0] acc_q;
    logic signed [CNT_W-1:0] acc_d;
    logic signed [1:0]       contrib;
    logic signed [CNT_W:0]   contrib_ext;
    logic signed [CNT_W:0]   acc_ext;
    logic signed [CNT_W:0]   sum;
    logic                    sat_q;
    logic                    clamp;

    // One guard bit lets the clamp see an overflow before it wraps.
    always_comb begin
        contrib     = !store ? ZERO : (hv_bit ? NEG_ONE : POS_ONE);
        contrib_ext = {{(CNT_W - 1){contrib[1]}}, contrib};
        acc_ext     = {acc_q[CNT_W-1], acc_q};
        sum         = acc_ext + contrib_ext;
        clamp       = 1'b0;
        acc_d       = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            if (sum > MAX) begin
                acc_d = MAX[CNT_W-1:0];
                clamp = 1'b1;
            end else if (sum < MIN) begin
                acc_d = MIN[CNT_W-1:0];
                clamp = 1'b1;
            end else begin
                acc_d = sum[CNT_W-1:0];
            end
        end
    end

    assign sign = acc_d[CNT_W-1];
    assign zero = (acc_d == '0);
    assign sat  = !clr && (sat_q || clamp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat;
        end
    end
endmodule

// File: rtl/bipolar_bundler.sv
// Multi-lane HDC bundler: accumulates bipolar beats per lane and emits the sign
// hypervector. Define BUNDLE_TIEBREAK_EN to break zero-sum ties with an LFSR.
module bipolar_bundler
    import hpu_bundle_pkg::*;
#(
    parameter int LANES  = 32,
    parameter int CNT_W  = 8,
    parameter int BEAT_W = 16
) (
    input logic              clk,
    input logic              rst,
    bipolar_bundler_if.slave bus
);
    state_t            state;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              out_sat_q;
    logic [LANES-1:0]  out_bits_q;
    logic [LANES-1:0]  result_bits;
    logic [LANES-1:0]  tie_bits;
    logic [LANES-1:0]  lane_sign;
    logic [LANES-1:0]  lane_zero;
    logic [LANES-1:0]  lane_sat;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_cnt_next;
    logic [BEAT_W-1:0] out_beats_q;
    logic              clr;
    logic              beat;

    assign clr           = (state == IDLE) && bus.start;
    assign beat          = (state == ACC) && bus.in_valid;
    assign beat_cnt_next = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bundle_lane #(.CNT_W(CNT_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .en     (beat),
            .store  (bus.in_store),
            .hv_bit (bus.in_bits[i]),
            .sign   (lane_sign[i]),
            .zero   (lane_zero[i]),
            .sat    (lane_sat[i])
        );
    end

`ifdef BUNDLE_TIEBREAK_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_next;

    assign lfsr_next = lfsr_step(lfsr_q);

    // Ties use the value the LFSR moves to on the DONE-entry edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (beat && bus.in_last) begin
            lfsr_q <= lfsr_next;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_tie
        assign tie_bits[i] = lfsr_next[i % 16];
    end
`else
    assign tie_bits = '0;
`endif

    assign result_bits = (lane_zero & tie_bits) | (~lane_zero & lane_sign);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_beats_q <= '0;
            out_sat_q   <= 1'b0;
            beat_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= ACC;
                        in_ready_q <= 1'b1;
                        beat_cnt   <= '0;
                        out_sat_q  <= 1'b0;
                    end
                end
                ACC: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt_next;
                        if (bus.in_last) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_bits_q  <= result_bits;
                            out_beats_q <= beat_cnt_next;
                            out_sat_q   <= |lane_sat;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bits  = out_bits_q;
    assign bus.out_beats = out_beats_q;
    assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_bipolar_bundler.sv
// Directed bench for bipolar_bundler with 4 lanes, 4-bit accumulators and a
// 3-bit beat counter so counter saturation is reachable in a short burst.
module tb_bipolar_bundler;
    localparam int LANES  = 4;
    localparam int CNT_W  = 4;
    localparam int BEAT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bipolar_bundler_if #(.LANES(LANES), .BEAT_W(BEAT_W)) bus ();

    bipolar_bundler #(.LANES(LANES), .CNT_W(CNT_W), .BEAT_W(BEAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       first;
        logic [3:0] bits;
        logic       store;
        logic       last;
        logic [3:0] exp_bits;
        logic [3:0] exp_tie;
        logic [2:0] exp_beats;
        logic       exp_sat;
    } vec_t;

    vec_t        vecs[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] lfsr_model = 16'hACE1;

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic void add(input logic first, input logic [3:0] bits, input logic store,
                                input logic last, input logic [3:0] exp_bits,
                                input logic [3:0] exp_tie, input logic [2:0] exp_beats,
                                input logic exp_sat);
        vec_t v;
        v.first = first; v.bits = bits; v.store = store; v.last = last;
        v.exp_bits = exp_bits; v.exp_tie = exp_tie; v.exp_beats = exp_beats; v.exp_sat = exp_sat;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected tie lanes take model LFSR bits when the tie-break is built.
    function automatic logic [3:0] resolve(input logic [3:0] base, input logic [3:0] tie);
        logic [3:0] r;
        r = base;
`ifdef BUNDLE_TIEBREAK_EN
        r = (base & ~tie) | (lfsr_model[3:0] & tie);
`endif
        return r;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        if (v.first) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            check_output("in_ready_after_start", {15'd0, bus.in_ready}, 16'd1);
        end
        bus.in_valid = 1'b1;
        bus.in_bits  = v.bits;
        bus.in_store = v.store;
        bus.in_last  = v.last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (v.last) begin
            lfsr_model = model_step(lfsr_model);
            check_output("out_valid_last", {15'd0, bus.out_valid}, 16'd1);
            check_output("in_ready_done", {15'd0, bus.in_ready}, 16'd0);
            check_output("out_bits", {12'd0, bus.out_bits}, {12'd0, resolve(v.exp_bits, v.exp_tie)});
            check_output("out_beats", {13'd0, bus.out_beats}, {13'd0, v.exp_beats});
            check_output("out_sat", {15'd0, bus.out_sat}, {15'd0, v.exp_sat});
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            check_output("out_valid_popped", {15'd0, bus.out_valid}, 16'd0);
        end else begin
            check_output("out_valid_mid", {15'd0, bus.out_valid}, 16'd0);
            check_output("in_ready_mid", {15'd0, bus.in_ready}, 16'd1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_in_ready"}, {15'd0, bus.in_ready}, 16'd0);
        check_output({tag, "_out_valid"}, {15'd0, bus.out_valid}, 16'd0);
        check_output({tag, "_out_bits"}, {12'd0, bus.out_bits}, 16'd0);
        check_output({tag, "_out_beats"}, {13'd0, bus.out_beats}, 16'd0);
        check_output({tag, "_out_sat"}, {15'd0, bus.out_sat}, 16'd0);
    endtask

    initial begin
        vec_t one;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_store = 1'b0;
        bus.in_bits = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;

        // Lanes: +1 for bit 0, -1 for bit 1; out bit is 1 for a negative sum.
        add(1, 4'b0000, 1, 0, 0, 0, 0, 0);
        add(0, 4'b0101, 1, 0, 0, 0, 0, 0);
        add(0, 4'b0101, 1, 1, 4'b0101, 4'b0000, 3'd3, 0);
        add(1, 4'b1111, 1, 0, 0, 0, 0, 0);
        add(0, 4'b1111, 0, 0, 0, 0, 0, 0);
        add(0, 4'b1111, 0, 0, 0, 0, 0, 0);
        add(0, 4'b1111, 1, 1, 4'b1111, 4'b0000, 3'd4, 0);
        for (int i = 0; i < 8; i++) add(i == 0, 4'b0000, 1, 0, 0, 0, 0, 0);
        add(0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 3'd7, 1);
        add(1, 4'b0011, 1, 0, 0, 0, 0, 0);
        add(0, 4'b1100, 1, 1, 4'b0000, 4'b1111, 3'd2, 0);
        add(1, 4'b1111, 0, 1, 4'b0000, 4'b1111, 3'd1, 0);
        for (int i = 0; i < 7; i++) add(i == 0, 4'b1010, 1, 0, 0, 0, 0, 0);
        add(0, 4'b1010, 1, 1, 4'b1010, 4'b0000, 3'd7, 1);
        add(1, 4'b0110, 1, 0, 0, 0, 0, 0);
        add(0, 4'b0011, 1, 0, 0, 0, 0, 0);
        add(0, 4'b0000, 1, 1, 4'b0010, 4'b0000, 3'd3, 0);

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Backpressure: result held, beats and start ignored while in DONE.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_bits = 4'b0110; bus.in_store = 1'b1; bus.in_last = 1'b1;
        tick();
        lfsr_model = model_step(lfsr_model);
        for (int c = 0; c < 5; c++) begin
            bus.in_bits = 4'b1111;
            bus.start   = c[0];
            tick();
            check_output("bp_out_valid", {15'd0, bus.out_valid}, 16'd1);
            check_output("bp_in_ready", {15'd0, bus.in_ready}, 16'd0);
            check_output("bp_out_bits", {12'd0, bus.out_bits}, 16'h0006);
            check_output("bp_out_beats", {13'd0, bus.out_beats}, 16'd1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        check_output("pop_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check_output("pop_start_ignored", {15'd0, bus.in_ready}, 16'd0);

        // Beats presented in IDLE must not produce a result.
        bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.in_bits = 4'b1111;
        repeat (2) begin
            tick();
            check_output("idle_beat_out_valid", {15'd0, bus.out_valid}, 16'd0);
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        one = '{first: 1'b1, bits: 4'b0000, store: 1'b1, last: 1'b1, exp_bits: 4'b0000,
                exp_tie: 4'b0000, exp_beats: 3'd1, exp_sat: 1'b0};
        apply_stimulus(one);

        // Async reset between edges mid-burst.
        one = '{first: 1'b1, bits: 4'b1111, store: 1'b1, last: 1'b0, exp_bits: 4'b0000,
                exp_tie: 4'b0000, exp_beats: 3'd0, exp_sat: 1'b0};
        apply_stimulus(one);
        one.first = 1'b0;
        apply_stimulus(one);
        #3 rst = 1'b1;
        #1;
        check_all_zero("rst_mid_burst");
        tick();
        rst = 1'b0;
        lfsr_model = 16'hACE1;
        one = '{first: 1'b1, bits: 4'b0001, store: 1'b1, last: 1'b1, exp_bits: 4'b0001,
                exp_tie: 4'b0000, exp_beats: 3'd1, exp_sat: 1'b0};
        apply_stimulus(one);

        // Async reset while holding a result in DONE.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_bits = 4'b1111; bus.in_store = 1'b1; bus.in_last = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        check_output("done_before_rst", {15'd0, bus.out_valid}, 16'd1);
        #3 rst = 1'b1;
        #1;
        check_all_zero("rst_in_done");
        tick();
        rst = 1'b0;
        lfsr_model = 16'hACE1;
        one = '{first: 1'b1, bits: 4'b1100, store: 1'b1, last: 1'b1, exp_bits: 4'b1100,
                exp_tie: 4'b0000, exp_beats: 3'd1, exp_sat: 1'b0};
        apply_stimulus(one);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
